wordcopy_engine: RTL and testbench
==================================

Name: wordcopy_engine

Overview:
- Memory-mapped word-copy (mini-DMA) engine with an Avalon-MM slave port for control and an Avalon-MM master port to SDRAM.
- Software writes destination, source and word count, then writes the start register.
- The engine reads each 32-bit word from the source and writes it to the destination, one word at a time.
- The slave port stalls (slave_waitrequest high) until the copy completes.

Parameters:
- None. Data and address widths are fixed at 32 bits, word-aligned byte addressing.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- slave_waitrequest  out  1  stall slave accesses while copy in progress
- slave_address  in  4  word index of control register
- slave_read  in  1  slave read strobe
- slave_readdata  out  32  slave read data
- slave_write  in  1  slave write strobe
- slave_writedata  in  32  slave write data
- master_waitrequest  in  1  SDRAM not ready to accept command
- master_address  out  32  SDRAM byte address
- master_read  out  1  SDRAM read command
- master_readdata  in  32  SDRAM read data
- master_readdatavalid  in  1  master_readdata valid this cycle
- master_write  out  1  SDRAM write command
- master_writedata  out  32  SDRAM write data

Behaviour:
- Registers (slave_address):
  - 0 = start (write any value) / status
  - 1 = destination byte address
  - 2 = source byte address
  - 3 = number of words
  - Config writes are accepted only in IDLE and take effect at the next clock edge.
- Slave reads of 1..3 return the register value; reads of 0 and all other addresses return 0.
- State encoding (4 bits):
  - IDLE=1, RD_REQ=2, RD_WAIT=3, WR_REQ=4, WR_HOLD=5, DONE=6.
- Reset:
  - state IDLE; destination, source, count, word counter and captured word cleared.
  - Master read/write 0, master_address 0, slave_waitrequest 0, slave_readdata 0.
  - Reset mid-copy aborts immediately with no further master commands.
- IDLE:
  - slave_waitrequest=0.
  - slave_write to address 0 → RD_REQ next cycle; word counter and address offset cleared.
  - If count=0 → DONE directly, with no master accesses.
- RD_REQ:
  - master_read=1, master_address=source+4*i.
  - Stay while master_waitrequest=1; → RD_WAIT when master_waitrequest=0.
- RD_WAIT:
  - Master commands deasserted.
  - On master_readdatavalid=1, capture master_readdata into the word register → WR_REQ; otherwise stay.
- WR_REQ:
  - master_write=1, master_address=destination+4*i, master_writedata=captured word.
  - → WR_HOLD when master_waitrequest=0.
- WR_HOLD:
  - Same master outputs held, so an idempotent re-write of the same word is allowed.
  - Stay while master_waitrequest=1.
  - When master_waitrequest=0:
    - if i == count-1 (word_count_finished), assert counter/address reset → DONE;
    - else i increments, offset +4 → RD_REQ.
- DONE:
  - slave_waitrequest=0 → IDLE next cycle.
- slave_waitrequest:
  - 1 in every state RD_REQ..WR_HOLD regardless of slave strobes.
  - A slave read of address 0 issued during a copy therefore completes only after the copy finishes.
  - Slave writes during a copy are stalled and then applied in IDLE.
- Arithmetic: address arithmetic is modulo 2^32 (wraps silently); word counter is 32 bits.
- master_read and master_write are never asserted together.

Optional Feature:
- Macro WORDCOPY_STATUS_EN.
- Defined:
  - slave address 4 is a non-stalling status register.
  - Reads of it never assert slave_waitrequest and return {31'b0, busy}, busy=1 in states RD_REQ..WR_HOLD.
  - Only reads of other addresses stall during a copy.
- Undefined: address 4 behaves like any unused address (reads 0, stalls during copy as above).

Test Plan:
- Reset: assert reset for one cycle → state=1, slave_waitrequest=0, master_read=master_write=0.
- Config: write dst=400000, src=10, count=1 → registers read back 400000/10/1, state stays 1.
- Single-word copy:
  - write addr 0, then master_waitrequest=1 → state 2, master_read=1, master_address=10.
  - Drop waitrequest → state 3.
  - readdatavalid with data 100 → captured word 100, state 4.
  - Write phase shows master_address=400000, master_writedata=100, master_write=1, held through WR_HOLD waitrequest.
  - Then DONE (slave_waitrequest=0) → IDLE.
- Multi-word: src=0x100, dst=0x200, count=3 with a memory model that has random waitrequest → destination words 0x200/0x204/0x208 equal source words; exactly 3 reads issued.
- Zero count: count=0, start → IDLE→DONE→IDLE with no master_read/master_write pulses.
- Reset mid-copy: assert reset while in state 3 → state 1 next cycle, master strobes 0, counter cleared.

Source files
------------

// File: rtl/wordcopy_engine.sv
// Word-copy mini-DMA: Avalon-MM slave for control, Avalon-MM master to SDRAM.
// Optional non-stalling status register at slave address 4 under `WORDCOPY_STATUS_EN.
module wordcopy_engine (
  input  logic        clock,
  input  logic        reset,
  output logic        slave_waitrequest,
  input  logic [3:0]  slave_address,
  input  logic        slave_read,
  output logic [31:0] slave_readdata,
  input  logic        slave_write,
  input  logic [31:0] slave_writedata,
  input  logic        master_waitrequest,
  output logic [31:0] master_address,
  output logic        master_read,
  input  logic [31:0] master_readdata,
  input  logic        master_readdatavalid,
  output logic        master_write,
  output logic [31:0] master_writedata
);

  typedef enum logic [3:0] {
    IDLE    = 4'd1,
    RD_REQ  = 4'd2,
    RD_WAIT = 4'd3,
    WR_REQ  = 4'd4,
    WR_HOLD = 4'd5,
    DONE    = 4'd6
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] dst_addr, src_addr, num_words;
  logic [31:0] word_idx, idx_nxt;
  logic [31:0] offset, off_nxt;
  logic [31:0] word_q, word_nxt;
  logic        busy, last_word, cfg_we;

  assign busy      = (state == RD_REQ) || (state == RD_WAIT) ||
                     (state == WR_REQ) || (state == WR_HOLD);
  assign last_word = (word_idx == num_words - 32'd1);
  assign cfg_we    = (state == IDLE) && slave_write;

`ifdef WORDCOPY_STATUS_EN
  logic status_rd;
  assign status_rd         = slave_read && (slave_address == 4'd4);
  assign slave_waitrequest = busy && !status_rd;
`else
  assign slave_waitrequest = busy;
`endif

  always_comb begin
    slave_readdata = '0;
    if (slave_read) begin
      case (slave_address)
        4'd1: slave_readdata = dst_addr;
        4'd2: slave_readdata = src_addr;
        4'd3: slave_readdata = num_words;
`ifdef WORDCOPY_STATUS_EN
        4'd4: slave_readdata = {31'b0, busy};
`endif
        default: slave_readdata = '0;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = word_idx;
    off_nxt   = offset;
    word_nxt  = word_q;
    case (state)
      IDLE: begin
        if (slave_write && (slave_address == 4'd0)) begin
          idx_nxt   = '0;
          off_nxt   = '0;
          state_nxt = (num_words == '0) ? DONE : RD_REQ;
        end
      end
      RD_REQ:  if (!master_waitrequest) state_nxt = RD_WAIT;
      RD_WAIT: begin
        if (master_readdatavalid) begin
          word_nxt  = master_readdata;
          state_nxt = WR_REQ;
        end
      end
      WR_REQ:  if (!master_waitrequest) state_nxt = WR_HOLD;
      WR_HOLD: begin
        // Second accepted write of the same word ends the word.
        if (!master_waitrequest) begin
          if (last_word) begin
            idx_nxt   = '0;
            off_nxt   = '0;
            state_nxt = DONE;
          end else begin
            idx_nxt   = word_idx + 32'd1;
            off_nxt   = offset + 32'd4;
            state_nxt = RD_REQ;
          end
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Master outputs are registered from the next state so they line up with it.
  always_ff @(posedge clock) begin
    if (reset) begin
      state            <= IDLE;
      dst_addr         <= '0;
      src_addr         <= '0;
      num_words        <= '0;
      word_idx         <= '0;
      offset           <= '0;
      word_q           <= '0;
      master_read      <= 1'b0;
      master_write     <= 1'b0;
      master_address   <= '0;
      master_writedata <= '0;
    end else begin
      state        <= state_nxt;
      word_idx     <= idx_nxt;
      offset       <= off_nxt;
      word_q       <= word_nxt;
      master_read  <= (state_nxt == RD_REQ);
      master_write <= (state_nxt == WR_REQ) || (state_nxt == WR_HOLD);
      if (state_nxt == RD_REQ) begin
        master_address <= src_addr + off_nxt;
      end else if ((state_nxt == WR_REQ) || (state_nxt == WR_HOLD)) begin
        master_address   <= dst_addr + off_nxt;
        master_writedata <= word_nxt;
      end
      if (cfg_we) begin
        case (slave_address)
          4'd1:    dst_addr  <= slave_writedata;
          4'd2:    src_addr  <= slave_writedata;
          4'd3:    num_words <= slave_writedata;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_wordcopy_engine.sv
// Self-checking bench for wordcopy_engine: directed handshake steps plus a
// random-waitrequest memory model with a write scoreboard.
module tb_wordcopy_engine;

  logic        clock, reset;
  logic        slave_waitrequest;
  logic [3:0]  slave_address;
  logic        slave_read, slave_write;
  logic [31:0] slave_readdata, slave_writedata;
  logic        master_waitrequest, master_readdatavalid;
  logic [31:0] master_address, master_readdata, master_writedata;
  logic        master_read, master_write;

  // Inputs come either from the directed stimulus or from the memory model.
  logic        dir_mode, dir_wait, dir_rdv;
  logic [31:0] dir_rdata;
  logic        mdl_wait, mdl_rdv, mem_rand;
  logic [31:0] mdl_rdata;
  assign master_waitrequest   = dir_mode ? dir_wait  : mdl_wait;
  assign master_readdatavalid = dir_mode ? dir_rdv   : mdl_rdv;
  assign master_readdata      = dir_mode ? dir_rdata : mdl_rdata;

  wordcopy_engine dut (
    .clock(clock), .reset(reset),
    .slave_waitrequest(slave_waitrequest), .slave_address(slave_address),
    .slave_read(slave_read), .slave_readdata(slave_readdata),
    .slave_write(slave_write), .slave_writedata(slave_writedata),
    .master_waitrequest(master_waitrequest), .master_address(master_address),
    .master_read(master_read), .master_readdata(master_readdata),
    .master_readdatavalid(master_readdatavalid), .master_write(master_write),
    .master_writedata(master_writedata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_vec, n_err;
  int rd_acc, rd_pulse, wr_pulse;

  typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;
  wr_t sb[$];
  bit [31:0] mem [bit [31:0]];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic wait_accept();
    int n;
    n = 0;
    forever begin
      @(negedge clock);
      if (!slave_waitrequest) break;
      n++;
      if (n > 3000) begin
        chk("slv_timeout", {31'b0, slave_waitrequest}, 32'd0);
        break;
      end
    end
  endtask

  task automatic slv_write(input logic [3:0] a, input logic [31:0] d);
    slave_address = a; slave_writedata = d; slave_write = 1'b1;
    wait_accept();
    tick();
    slave_write = 1'b0;
  endtask

  task automatic slv_read(input logic [3:0] a, output logic [31:0] d);
    slave_address = a; slave_read = 1'b1;
    wait_accept();
    d = slave_readdata;
    tick();
    slave_read = 1'b0;
  endtask

  // Memory model: handshakes are judged mid-cycle, responses driven after the edge.
  initial begin
    int dly;
    bit pend;
    logic [31:0] paddr;
    wr_t e;
    dly = 0; pend = 0; paddr = '0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        chk("rw_excl", {31'b0, master_read & master_write}, 32'd0);
        if (master_read)  rd_pulse++;
        if (master_write) wr_pulse++;
        if (master_read && !master_waitrequest) begin
          rd_acc++;
          if (!dir_mode) begin
            pend = 1; paddr = master_address; dly = $urandom_range(1, 3);
          end
        end
        if (master_write && !master_waitrequest && !dir_mode) begin
          if (sb.size() == 0) chk("wr_unexp", {31'b0, master_write}, 32'd0);
          else begin
            e = sb.pop_front();
            chk("wr_addr", master_address, e.addr);
            chk("wr_data", master_writedata, e.data);
            mem[master_address] = master_writedata;
          end
        end
      end
      @(posedge clock); #1;
      mdl_rdv = 1'b0;
      if (pend && !dir_mode) begin
        dly--;
        if (dly == 0) begin
          mdl_rdv = 1'b1;
          mdl_rdata = mem.exists(paddr) ? mem[paddr] : 32'd0;
          pend = 0;
        end
      end
      mdl_wait = mem_rand ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  end

  task automatic run_copy(input logic [31:0] src, input logic [31:0] dst, input int n);
    logic [31:0] d, v;
    int base;
    wr_t e;
    for (int k = 0; k < n; k++) begin
      v = $urandom;
      mem[src + 32'(4 * k)] = v;
      mem[dst + 32'(4 * k)] = 32'd0;
      e.addr = dst + 32'(4 * k); e.data = v;
      sb.push_back(e);
      sb.push_back(e);
    end
    base = rd_acc;
    slv_write(4'd1, dst);
    slv_write(4'd2, src);
    slv_write(4'd3, 32'(n));
    slv_write(4'd0, 32'd0);
    slv_read(4'd0, d);
    chk("stall_rd0", d, 32'd0);
    chk("rd_count", 32'(rd_acc - base), 32'(n));
    chk("sb_empty", 32'(sb.size()), 32'd0);
    for (int k = 0; k < n; k++)
      chk("dst_word", mem[dst + 32'(4 * k)], mem[src + 32'(4 * k)]);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    int rb, wb;
    n_vec = 0; n_err = 0; rd_acc = 0; rd_pulse = 0; wr_pulse = 0;
    reset = 1'b1; slave_address = '0; slave_read = 0; slave_write = 0; slave_writedata = '0;
    dir_mode = 1; dir_wait = 0; dir_rdv = 0; dir_rdata = '0;
    mdl_wait = 0; mdl_rdv = 0; mdl_rdata = '0; mem_rand = 0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_swait", {31'b0, slave_waitrequest}, 32'd0);
    chk("rst_mrd", {31'b0, master_read}, 32'd0);
    chk("rst_mwr", {31'b0, master_write}, 32'd0);
    chk("rst_maddr", master_address, 32'd0);
    slv_read(4'd3, d); chk("rst_cnt", d, 32'd0);

    // Configuration read-back
    slv_write(4'd1, 32'd400000);
    slv_write(4'd2, 32'd10);
    slv_write(4'd3, 32'd1);
    slv_read(4'd1, d); chk("cfg_dst", d, 32'd400000);
    slv_read(4'd2, d); chk("cfg_src", d, 32'd10);
    slv_read(4'd3, d); chk("cfg_cnt", d, 32'd1);
    slv_read(4'd4, d); chk("rd_addr4", d, 32'd0);
    slv_read(4'd9, d); chk("rd_unused", d, 32'd0);

    // Single-word copy, one handshake step at a time
    rb = rd_acc;
    dir_wait = 1;
    slv_write(4'd0, 32'd0);
    chk("rq_mrd", {31'b0, master_read}, 32'd1);
    chk("rq_maddr", master_address, 32'd10);
    chk("rq_swait", {31'b0, slave_waitrequest}, 32'd1);
    tick();
    chk("rq_hold", {31'b0, master_read}, 32'd1);
    dir_wait = 0;
    tick();
    chk("rw_mrd", {31'b0, master_read}, 32'd0);
    chk("rw_mwr", {31'b0, master_write}, 32'd0);
    chk("rw_nacc", 32'(rd_acc - rb), 32'd1);
    tick();
    chk("rw_stay", {31'b0, master_write}, 32'd0);
    dir_rdv = 1; dir_rdata = 32'd100; dir_wait = 1;
    tick();
    dir_rdv = 0; dir_rdata = 32'hdead_beef;
    chk("wq_mwr", {31'b0, master_write}, 32'd1);
    chk("wq_maddr", master_address, 32'd400000);
    chk("wq_wdata", master_writedata, 32'd100);
    tick();
    chk("wq_hold", {31'b0, master_write}, 32'd1);
    dir_wait = 0;
    tick();
    dir_wait = 1;
    chk("wh_mwr", {31'b0, master_write}, 32'd1);
    chk("wh_maddr", master_address, 32'd400000);
    chk("wh_wdata", master_writedata, 32'd100);
    tick();
    chk("wh_hold", {31'b0, master_write}, 32'd1);
    chk("wh_swait", {31'b0, slave_waitrequest}, 32'd1);
    dir_wait = 0;
    tick();
    chk("dn_swait", {31'b0, slave_waitrequest}, 32'd0);
    chk("dn_mwr", {31'b0, master_write}, 32'd0);
    tick();
    chk("id_mrd", {31'b0, master_read}, 32'd0);

    // Zero count: no master traffic
    slv_write(4'd3, 32'd0);
    rb = rd_pulse; wb = wr_pulse;
    slv_write(4'd0, 32'd0);
    chk("z_swait", {31'b0, slave_waitrequest}, 32'd0);
    tick(); tick(); tick();
    chk("z_rd", 32'(rd_pulse - rb), 32'd0);
    chk("z_wr", 32'(wr_pulse - wb), 32'd0);

    // Random-waitrequest memory copies, including address wrap
    dir_mode = 0; mem_rand = 1;
    run_copy(32'h100, 32'h200, 3);
    run_copy(32'hFFFF_FFF8, 32'h300, 3);
    run_copy(32'h1000, 32'h2000, 5);
    mem_rand = 0;
    tick(); tick();
    dir_mode = 1; dir_wait = 0; dir_rdv = 0;

    // Reset while waiting for read data
    slv_write(4'd1, 32'h80);
    slv_write(4'd2, 32'h40);
    slv_write(4'd3, 32'd2);
    slv_write(4'd0, 32'd0);
    tick();
    chk("mr_rwait", {31'b0, master_read}, 32'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mr_mrd", {31'b0, master_read}, 32'd0);
    chk("mr_mwr", {31'b0, master_write}, 32'd0);
    chk("mr_swait", {31'b0, slave_waitrequest}, 32'd0);
    rb = rd_pulse; wb = wr_pulse;
    dir_rdv = 1; dir_rdata = 32'h55;
    tick(); tick(); tick();
    dir_rdv = 0;
    chk("mr_nord", 32'(rd_pulse - rb), 32'd0);
    chk("mr_nowr", 32'(wr_pulse - wb), 32'd0);
    slv_read(4'd3, d); chk("mr_cnt", d, 32'd0);
    slv_read(4'd2, d); chk("mr_src", d, 32'd0);
    slv_write(4'd2, 32'h40);
    slv_write(4'd3, 32'd2);
    dir_wait = 1;
    slv_write(4'd0, 32'd0);
    chk("mr_restart", master_address, 32'h40);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    dir_wait = 0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
